// File: rtl/hello_uart_tx.sv
// hello_uart_tx: sends the fixed string "Hello World!\r\n" as 8N1 UART frames.
// Each bit (start, data, stop) is held for CLK_DIV clock cycles. All outputs
// are registered, so there is no combinational path from start to any output.
//
// Handshake: start is a level request that is only looked at in IDLE. A high
// start sampled in IDLE launches one full 14-byte message; busy is high for
// the whole message, and start is ignored until done has pulsed. If start is
// still high in the done cycle, the next message follows after exactly one
// idle-high tx cycle.
module hello_uart_tx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [3:0] char_idx,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_CHAR   = 4'd13;

    state_t      state, state_n;
    logic [7:0]  shift_reg, shift_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [15:0] baud_cnt, baud_n;
    logic [3:0]  idx_n;
    logic        tx_n, busy_n, done_n;

    // Message ROM; indices 14 and 15 are never reached.
    function automatic logic [7:0] msg_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    msg_rom = 8'h48;
            4'd1:    msg_rom = 8'h65;
            4'd2:    msg_rom = 8'h6C;
            4'd3:    msg_rom = 8'h6C;
            4'd4:    msg_rom = 8'h6F;
            4'd5:    msg_rom = 8'h20;
            4'd6:    msg_rom = 8'h57;
            4'd7:    msg_rom = 8'h6F;
            4'd8:    msg_rom = 8'h72;
            4'd9:    msg_rom = 8'h6C;
            4'd10:   msg_rom = 8'h64;
            4'd11:   msg_rom = 8'h21;
            4'd12:   msg_rom = 8'h0D;
            4'd13:   msg_rom = 8'h0A;
            default: msg_rom = 8'h00;
        endcase
    endfunction

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
            baud_cnt  <= 16'd0;
            char_idx  <= 4'd0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= bit_n;
            baud_cnt  <= baud_n;
            char_idx  <= idx_n;
            tx        <= tx_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state logic; outputs are computed for the next cycle so they can be registered.
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        bit_n   = bit_cnt;
        baud_n  = baud_cnt;
        idx_n   = char_idx;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    shift_n = msg_rom(char_idx);
                    bit_n   = 3'd0;
                    baud_n  = BAUD_RELOAD;
                    state_n = S_START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end

            S_START: begin
                if (baud_cnt == 16'd0) begin
                    baud_n  = BAUD_RELOAD;
                    state_n = S_DATA;
                    tx_n    = shift_reg[0];
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end

            S_DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_n  = BAUD_RELOAD;
                    shift_n = shift_reg >> 1;
                    if (bit_cnt == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                        tx_n  = shift_reg[1];
                    end
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end

            S_STOP: begin
                if (baud_cnt == 16'd0) begin
                    if (char_idx < LAST_CHAR) begin
                        // Back-to-back frames: next start bit follows the stop bit directly.
                        idx_n   = char_idx + 4'd1;
                        shift_n = msg_rom(char_idx + 4'd1);
                        bit_n   = 3'd0;
                        baud_n  = BAUD_RELOAD;
                        state_n = S_START;
                        tx_n    = 1'b0;
                    end else begin
                        idx_n   = 4'd0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end
                end else begin
                    baud_n = baud_cnt - 16'd1;
                end
            end

            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Debug view of the FSM state.
    assign dbg_state = state;

endmodule

// File: tb/tb_hello_uart_tx.sv
// Bench for hello_uart_tx at CLK_DIV = 4: clock/reset block, driver tasks,
// a per-cycle reference of the serial waveform, a UART decoding scoreboard
// with an expected byte queue, and a final report.
module tb_hello_uart_tx;

  localparam int D      = 4;
  localparam int FRAME  = 10 * D;
  localparam int MSG_CY = 14 * FRAME;

  logic       clock;
  logic       reset;
  logic       start;
  logic       tx;
  logic       busy;
  logic       done;
  logic [3:0] char_idx;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_done_cyc = 0;

  logic [7:0] msg [0:13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  hello_uart_tx #(.CLK_DIV(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .char_idx (char_idx),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: line level at cycle k of a message (k = 0 is the first start-bit cycle).
  function automatic logic exp_tx(input int k);
    int b;
    int pos;
    logic [7:0] byte_v;
    b = k / FRAME;
    pos = (k % FRAME) / D;
    byte_v = msg[b];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return byte_v[pos - 1];
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx"}, 32'(tx), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_idx"}, 32'(char_idx), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      step();
      check_idle_outputs("idle");
    end
  endtask

  task automatic compare_rx();
    chk("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      chk("rx_byte", 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  // Called in the first start-bit cycle. Checks every cycle of the message,
  // decodes the line mid-bit, optionally re-pulses start or aborts with reset.
  task automatic run_msg(input bit hold, input int n_rep, input int abort_at);
    int rep_k[$];
    logic [7:0] rx_byte;
    bit pulse;
    int pos;
    rx_byte = 8'h00;
    for (int i = 0; i < n_rep; i++) rep_k.push_back(int'($urandom_range(20, MSG_CY - 60)));
    for (int i = 0; i < 14; i++) exp_q.push_back(msg[i]);
    for (int k = 0; k < MSG_CY; k++) begin
      pulse = 1'b0;
      foreach (rep_k[j]) if (rep_k[j] == k) pulse = 1'b1;
      start = hold | pulse;
      chk("msg_tx", 32'(tx), 32'(exp_tx(k)));
      chk("msg_busy", 32'(busy), 32'd1);
      chk("msg_done", 32'(done), 32'd0);
      chk("msg_idx", 32'(char_idx), 32'(k / FRAME));
      pos = (k % FRAME) / D;
      if ((k % D) == D / 2) begin
        if (pos >= 1 && pos <= 8) rx_byte[pos - 1] = tx;
        if (pos == 9) rx_q.push_back(rx_byte);
      end
      if (k == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        step();
        reset = 1'b0;
        check_idle_outputs("abort");
        rx_q.delete();
        exp_q.delete();
        return;
      end
      step();
    end
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_tx", 32'(tx), 32'd1);
    chk("end_idx", 32'(char_idx), 32'd0);
    last_done_cyc = cyc;
    compare_rx();
  endtask

  initial begin
    int d1;
    reset = 1'b1;
    start = 1'b1;

    // reset with start held: reset wins
    step();
    check_idle_outputs("rst0");
    step();
    check_idle_outputs("rst1");
    reset = 1'b0;
    start = 1'b0;
    idle(20);

    // single pulse: first frame and full message
    start = 1'b1;
    step();
    run_msg(1'b0, 0, -1);
    idle(int'($urandom_range(2, 8)));

    // start re-pulsed while busy: ignored
    start = 1'b1;
    step();
    run_msg(1'b0, 3, -1);
    idle(int'($urandom_range(5, 10)));

    // continuous start: two messages, one idle-high cycle between them
    start = 1'b1;
    step();
    run_msg(1'b1, 0, -1);
    d1 = last_done_cyc;
    step();
    run_msg(1'b0, 0, -1);
    chk("done_spacing", 32'(last_done_cyc - d1), 32'd561);
    idle(4);

    // reset during data bit 3 of byte 5, then a clean message
    start = 1'b1;
    step();
    run_msg(1'b0, 0, 5 * FRAME + 4 * D + int'($urandom_range(0, D - 1)));
    idle(3);
    start = 1'b1;
    step();
    run_msg(1'b0, 0, -1);
    idle(4);

    // random gaps and random re-pulses
    for (int r = 0; r < 2; r++) begin
      idle(int'($urandom_range(1, 12)));
      start = 1'b1;
      step();
      run_msg(1'b0, int'($urandom_range(0, 5)), -1);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
